// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using iterative shift-add-3 ("double dabble").
// Converts one bit per cycle and reports a registered result with an overflow flag.
`timescale 1ns/1ps

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]   scratch_q;
  logic            ovf_q;
  logic [CW-1:0]   count_q;
  logic [BW-1:0]   bcd_q;
  logic            overflow_q;
  logic            out_valid_q;

  logic [BW-1:0]    adj_d;
  logic [BW-1:0]    scratch_d;
  logic [WIDTH-1:0] bin_d;
  logic             carry_d;

  // One double-dabble step: per-digit +3 correction, then a 1-bit left shift
  // of {scratch, bin}. The bit leaving the top digit is the overflow carry.
  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    carry_d   = adj_d[BW-1];
    scratch_d = {adj_d[BW-2:0], bin_q[WIDTH-1]};
    bin_d     = bin_q << 1;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_q     <= bin;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            count_q   <= CW'(WIDTH);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          bin_q     <= bin_d;
          ovf_q     <= ovf_q | carry_d;
          count_q   <= count_q - CW'(1);
          // Last bit: publish the result together with the sticky overflow.
          if (count_q == CW'(1)) begin
            state_q     <= DONE;
            bcd_q       <= scratch_d;
            overflow_q  <= ovf_q | carry_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: four parameterisations sharing one clock and
// reset, checked against a decimal-division reference model.
`timescale 1ns/1ps

module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance index: 0 = (8,3), 1 = (4,2), 2 = (8,2), 3 = (1,1)
  int w_of [4] = '{8, 4, 8, 1};
  int d_of [4] = '{3, 2, 2, 1};

  logic        in_valid_a  [4];
  logic [7:0]  bin_a       [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic        ovf_w       [4];
  logic [11:0] bcd_w       [4];

  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [7:0]  bcd2;
  logic [3:0]  bcd3;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_w[0]),
    .bin(bin_a[0]), .out_valid(out_valid_w[0]), .bcd(bcd0), .overflow(ovf_w[0])
  );
  bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_w[1]),
    .bin(bin_a[1][3:0]), .out_valid(out_valid_w[1]), .bcd(bcd1), .overflow(ovf_w[1])
  );
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_w[2]),
    .bin(bin_a[2]), .out_valid(out_valid_w[2]), .bcd(bcd2), .overflow(ovf_w[2])
  );
  bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[3]), .in_ready(in_ready_w[3]),
    .bin(bin_a[3][0:0]), .out_valid(out_valid_w[3]), .bcd(bcd3), .overflow(ovf_w[3])
  );

  assign bcd_w[0] = bcd0;
  assign bcd_w[1] = {4'h0, bcd1};
  assign bcd_w[2] = {4'h0, bcd2};
  assign bcd_w[3] = {8'h00, bcd3};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v, input int digits);
    logic [11:0] r = '0;
    int t = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Starts and ends on a falling edge with the selected converter idle.
  task automatic convert(input int i, input int v);
    logic [11:0] exp_bcd;
    logic        exp_ovf;
    int          n;
    exp_bcd = to_bcd(v, d_of[i]);
    exp_ovf = (v >= pow10(d_of[i]));
    check($sformatf("ready_before[%0d:%0d]", i, v), 32'(in_ready_w[i]), 1);
    in_valid_a[i] = 1'b1;
    bin_a[i]      = 8'(v);
    @(negedge clk);
    in_valid_a[i] = 1'b0;
    bin_a[i]      = ~8'(v);
    check($sformatf("ready_busy[%0d:%0d]", i, v), 32'(in_ready_w[i]), 0);
    n = 0;
    while (!out_valid_w[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency[%0d:%0d]", i, v), 32'(n), 32'(w_of[i]));
    check($sformatf("ready_done[%0d:%0d]", i, v), 32'(in_ready_w[i]), 0);
    check($sformatf("overflow[%0d:%0d]", i, v), 32'(ovf_w[i]), 32'(exp_ovf));
    if (!exp_ovf) check($sformatf("bcd[%0d:%0d]", i, v), 32'(bcd_w[i]), 32'(exp_bcd));
    @(negedge clk);
    check($sformatf("pulse_end[%0d:%0d]", i, v), 32'(out_valid_w[i]), 0);
    check($sformatf("ready_idle[%0d:%0d]", i, v), 32'(in_ready_w[i]), 1);
    check($sformatf("bcd_hold[%0d:%0d]", i, v), 32'(ovf_w[i]), 32'(exp_ovf));
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_a[i] = 1'b0;
      bin_a[i]      = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready_w[0]), 0);
    check("rst_out_valid", 32'(out_valid_w[0]), 0);
    check("rst_bcd", 32'(bcd_w[0]), 0);
    check("rst_overflow", 32'(ovf_w[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready_w[0]), 1);

    // Full-scale value, then an exhaustive back-to-back sweep.
    convert(0, 255);
    for (int v = 0; v < 256; v++) convert(0, v);

    // Legacy 4-bit / two-digit equivalence.
    convert(1, 15);
    convert(1, 9);
    convert(1, 0);
    convert(1, 10);

    // Undersized digit count: overflow boundary at 100.
    convert(2, 99);
    convert(2, 100);
    convert(2, 0);
    convert(2, 255);

    // Single-bit operand, single shift cycle.
    convert(3, 1);
    convert(3, 0);
    convert(3, 1);

    // Operand and request toggled while busy must be ignored.
    in_valid_a[0] = 1'b1;
    bin_a[0]      = 8'd37;
    @(negedge clk);
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      if (j <= 6) begin
        in_valid_a[0] = (j % 2 == 0);
        bin_a[0]      = 8'd200;
      end else begin
        in_valid_a[0] = 1'b0;
      end
      if (out_valid_w[0]) begin
        pulses++;
        check("busy_ignore_lat", 32'(j), 8);
        check("busy_ignore_bcd", 32'(bcd_w[0]), 32'h037);
        check("busy_ignore_ovf", 32'(ovf_w[0]), 0);
      end
      @(negedge clk);
    end
    check("busy_ignore_pulses", 32'(pulses), 1);

    // Reset during the fourth shift cycle aborts the conversion.
    convert(0, 255);
    in_valid_a[0] = 1'b1;
    bin_a[0]      = 8'd200;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_rst", 32'(in_ready_w[0]), 0);
    check("abort_out_valid", 32'(out_valid_w[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(in_ready_w[0]), 1);
    check("abort_bcd", 32'(bcd_w[0]), 0);
    check("abort_ovf", 32'(ovf_w[0]), 0);
    pulses = 0;
    repeat (12) begin
      if (out_valid_w[0]) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", 32'(pulses), 0);
    convert(0, 142);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
